// File: rtl/wb_ram_if.sv
// Wishbone B4 pipelined bus bundle for wb_ram; signal names follow the slave's view.
// WB_RAM_ERR_EN adds the err_o completion signal.
interface wb_ram_if #(
  parameter int ADR_WIDTH = 16,
  parameter int DAT_WIDTH = 16
);
  logic                   cyc_i;
  logic                   stb_i;
  logic                   we_i;
  logic [ADR_WIDTH-1:0]   adr_i;
  logic [DAT_WIDTH/8-1:0] sel_i;
  logic [DAT_WIDTH-1:0]   dat_i;
  logic [DAT_WIDTH-1:0]   dat_o;
  logic                   ack_o;
  logic                   stall_o;
`ifdef WB_RAM_ERR_EN
  logic                   err_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    input  dat_o, ack_o, stall_o, err_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    output dat_o, ack_o, stall_o, err_o
  );
`else
  modport master (
    output cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    input  dat_o, ack_o, stall_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, sel_i, dat_i,
    output dat_o, ack_o, stall_o
  );
`endif
endinterface

// File: rtl/wb_ram.sv
// Single-port RAM behind a Wishbone B4 pipelined slave with byte lanes and programmable wait states.
// Optional macro WB_RAM_ERR_EN: out-of-range addresses complete with err_o instead of aliasing.
module wb_ram #(
  parameter int ADR_WIDTH   = 16,
  parameter int DAT_WIDTH   = 16,
  parameter int MEM_DEPTH   = 2**ADR_WIDTH,
  parameter int WAIT_STATES = 0
) (
  input  logic    clk,
  input  logic    rst,
  wb_ram_if.slave bus
);

  localparam int SEL_W = DAT_WIDTH / 8;
  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0]   CNT_LOAD = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
  localparam logic [ADR_WIDTH:0] DEPTH_W  = (ADR_WIDTH + 1)'(MEM_DEPTH);

  if (DAT_WIDTH % 8 != 0) begin : g_bad_dat_width
    $error("wb_ram: DAT_WIDTH must be a multiple of 8");
  end
  if (MEM_DEPTH < 1 || MEM_DEPTH > 2**ADR_WIDTH) begin : g_bad_depth
    $error("wb_ram: MEM_DEPTH must lie in 1..2**ADR_WIDTH");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait
    $error("wb_ram: WAIT_STATES must lie in 0..15");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam state_t ST_START = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;

  logic [DAT_WIDTH-1:0] mem [MEM_DEPTH];

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DAT_WIDTH-1:0] rdata_q;
  logic [IDX_W-1:0]     idx;
  logic                 in_range;
  logic                 stall;
  logic                 accept;
  logic                 completing;

  // Addresses beyond the implemented depth fold back modulo MEM_DEPTH.
  assign idx = IDX_W'({1'b0, bus.adr_i} % DEPTH_W);

`ifdef WB_RAM_ERR_EN
  assign in_range = ({1'b0, bus.adr_i} < DEPTH_W);
`else
  assign in_range = 1'b1;
`endif

  assign stall      = (state_q == ST_WAIT);
  assign accept     = bus.cyc_i & bus.stb_i & ~stall;
  assign completing = (state_q == ST_ACK) & bus.cyc_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_START;
          cnt_d   = CNT_LOAD;
        end
      end
      ST_WAIT: begin
        if (!bus.cyc_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_ACK;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_ACK: begin
        // The ACK cycle is not stalled, so a held strobe is taken here.
        if (accept) begin
          state_d = ST_START;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept && !bus.we_i && in_range) begin
        rdata_q <= mem[idx];
      end
    end
  end

  // Read-first: the read above samples mem before this edge's write lands.
  always_ff @(posedge clk) begin
    if (accept && bus.we_i && in_range) begin
      for (int n = 0; n < SEL_W; n++) begin
        if (bus.sel_i[n]) begin
          mem[idx][8*n +: 8] <= bus.dat_i[8*n +: 8];
        end
      end
    end
  end

  if (WAIT_STATES == 0) begin : g_direct
    assign bus.dat_o = rdata_q;
  end else begin : g_staged
    logic                 rd_pend_q;
    logic [DAT_WIDTH-1:0] dat_q;

    // dat_o only changes as a read's ack begins, so it holds through wait cycles.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_pend_q <= 1'b0;
        dat_q     <= '0;
      end else begin
        if (accept) begin
          rd_pend_q <= ~bus.we_i & in_range;
        end
        if (state_q == ST_WAIT && state_d == ST_ACK && rd_pend_q) begin
          dat_q <= rdata_q;
        end
      end
    end

    assign bus.dat_o = dat_q;
  end

`ifdef WB_RAM_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= ~in_range;
    end
  end

  assign bus.ack_o = completing & ~err_q;
  assign bus.err_o = completing &  err_q;
`else
  assign bus.ack_o = completing;
`endif

  assign bus.stall_o = stall;

endmodule

// File: tb/tb_wb_ram.sv
// Directed bench for wb_ram: zero-wait and three-wait instances, plus a 1K-deep instance
// exercising err_o when WB_RAM_ERR_EN is defined.
module tb_wb_ram;

  logic clk = 1'b0;
  logic rst;
  int   vectors    = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  wb_ram_if #(.ADR_WIDTH(16), .DAT_WIDTH(16)) bus0 ();
  wb_ram_if #(.ADR_WIDTH(16), .DAT_WIDTH(16)) bus3 ();

  wb_ram #(.ADR_WIDTH(16), .DAT_WIDTH(16), .WAIT_STATES(0)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  wb_ram #(.ADR_WIDTH(16), .DAT_WIDTH(16), .WAIT_STATES(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

`ifdef WB_RAM_ERR_EN
  wb_ram_if #(.ADR_WIDTH(16), .DAT_WIDTH(16)) buse ();

  wb_ram #(.ADR_WIDTH(16), .DAT_WIDTH(16), .MEM_DEPTH(1024), .WAIT_STATES(0)) u_dute (
    .clk (clk),
    .rst (rst),
    .bus (buse)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req0(input logic we, input logic [15:0] adr, input logic [1:0] sel, input logic [15:0] dat);
    bus0.cyc_i = 1'b1; bus0.stb_i = 1'b1; bus0.we_i = we;
    bus0.adr_i = adr;  bus0.sel_i = sel;  bus0.dat_i = dat;
  endtask

  task automatic idle0();
    bus0.cyc_i = 1'b0; bus0.stb_i = 1'b0; bus0.we_i = 1'b0;
  endtask

  task automatic req3(input logic we, input logic [15:0] adr, input logic [1:0] sel, input logic [15:0] dat);
    bus3.cyc_i = 1'b1; bus3.stb_i = 1'b1; bus3.we_i = we;
    bus3.adr_i = adr;  bus3.sel_i = sel;  bus3.dat_i = dat;
  endtask

  task automatic idle3();
    bus3.cyc_i = 1'b0; bus3.stb_i = 1'b0; bus3.we_i = 1'b0;
  endtask

  // Full-word write on the 3-wait instance, run to completion.
  task automatic wr3(input logic [15:0] adr, input logic [15:0] dat);
    req3(1'b1, adr, 2'b11, dat);
    tick();
    bus3.stb_i = 1'b0;
    repeat (4) tick();
    idle3();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    vectors++; if (bus0.ack_o !== 1'b0) begin miscompares++; $display("FAIL rst_ack0: got %b want 0", bus0.ack_o); end
    vectors++; if (bus0.stall_o !== 1'b0) begin miscompares++; $display("FAIL rst_stall0: got %b want 0", bus0.stall_o); end
    vectors++; if (bus0.dat_o !== 16'h0000) begin miscompares++; $display("FAIL rst_dat0: got %h want 0000", bus0.dat_o); end
    vectors++; if (bus3.stall_o !== 1'b0) begin miscompares++; $display("FAIL rst_stall3: got %b want 0", bus3.stall_o); end
    tick();
    tick();
    rst = 1'b0;
    tick();
    vectors++; if (bus0.ack_o !== 1'b0) begin miscompares++; $display("FAIL post_rst_ack0: got %b want 0", bus0.ack_o); end
    vectors++; if (bus0.stall_o !== 1'b0) begin miscompares++; $display("FAIL post_rst_stall0: got %b want 0", bus0.stall_o); end
    vectors++; if (bus0.dat_o !== 16'h0000) begin miscompares++; $display("FAIL post_rst_dat0: got %h want 0000", bus0.dat_o); end
  endtask

  task automatic test_byte_lanes();
    req0(1'b1, 16'h1234, 2'b11, 16'hA5C3);
    tick();
    vectors++; if (bus0.ack_o !== 1'b1) begin miscompares++; $display("FAIL bl_wr1_ack: got %b want 1", bus0.ack_o); end
    req0(1'b1, 16'h1234, 2'b01, 16'hFF00);
    tick();
    vectors++; if (bus0.ack_o !== 1'b1) begin miscompares++; $display("FAIL bl_wr2_ack: got %b want 1", bus0.ack_o); end
    req0(1'b0, 16'h1234, 2'b00, 16'h0000);
    tick();
    vectors++; if (bus0.ack_o !== 1'b1) begin miscompares++; $display("FAIL bl_rd_ack: got %b want 1", bus0.ack_o); end
    vectors++; if (bus0.dat_o !== 16'hA500) begin miscompares++; $display("FAIL bl_rd_dat: got %h want a500", bus0.dat_o); end
    idle0();
    tick();
    vectors++; if (bus0.ack_o !== 1'b0) begin miscompares++; $display("FAIL bl_idle_ack: got %b want 0", bus0.ack_o); end
    vectors++; if (bus0.dat_o !== 16'hA500) begin miscompares++; $display("FAIL bl_hold_dat: got %h want a500", bus0.dat_o); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp [4];
    exp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    for (int i = 0; i < 4; i++) begin
      req0(1'b1, 16'(i), 2'b11, exp[i]);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      req0(1'b0, 16'(i), 2'b11, 16'h0000);
      vectors++; if (bus0.stall_o !== 1'b0) begin miscompares++; $display("FAIL b2b_stall[%0d]: got %b want 0", i, bus0.stall_o); end
      tick();
      vectors++; if (bus0.ack_o !== 1'b1) begin miscompares++; $display("FAIL b2b_ack[%0d]: got %b want 1", i, bus0.ack_o); end
      vectors++; if (bus0.dat_o !== exp[i]) begin miscompares++; $display("FAIL b2b_dat[%0d]: got %h want %h", i, bus0.dat_o, exp[i]); end
    end
    idle0();
    tick();
    vectors++; if (bus0.ack_o !== 1'b0) begin miscompares++; $display("FAIL b2b_end_ack: got %b want 0", bus0.ack_o); end
  endtask

  task automatic test_wait_states();
    wr3(16'h0005, 16'h5A5A);
    wr3(16'h0006, 16'h6B6B);
    req3(1'b0, 16'h0005, 2'b11, 16'h0000);
    vectors++; if (bus3.stall_o !== 1'b0) begin miscompares++; $display("FAIL ws_stall_t0: got %b want 0", bus3.stall_o); end
    tick();
    bus3.adr_i = 16'h0006;
    for (int k = 1; k <= 3; k++) begin
      vectors++; if (bus3.stall_o !== 1'b1) begin miscompares++; $display("FAIL ws_stall_t%0d: got %b want 1", k, bus3.stall_o); end
      vectors++; if (bus3.ack_o !== 1'b0) begin miscompares++; $display("FAIL ws_ack_t%0d: got %b want 0", k, bus3.ack_o); end
      tick();
    end
    vectors++; if (bus3.ack_o !== 1'b1) begin miscompares++; $display("FAIL ws_ack_t4: got %b want 1", bus3.ack_o); end
    vectors++; if (bus3.stall_o !== 1'b0) begin miscompares++; $display("FAIL ws_stall_t4: got %b want 0", bus3.stall_o); end
    vectors++; if (bus3.dat_o !== 16'h5A5A) begin miscompares++; $display("FAIL ws_dat_t4: got %h want 5a5a", bus3.dat_o); end
    tick();
    bus3.stb_i = 1'b0;
    vectors++; if (bus3.stall_o !== 1'b1) begin miscompares++; $display("FAIL ws_held_accept: got %b want 1", bus3.stall_o); end
    vectors++; if (bus3.ack_o !== 1'b0) begin miscompares++; $display("FAIL ws_ack_t5: got %b want 0", bus3.ack_o); end
    tick();
    vectors++; if (bus3.dat_o !== 16'h5A5A) begin miscompares++; $display("FAIL ws_hold_dat: got %h want 5a5a", bus3.dat_o); end
    tick();
    tick();
    vectors++; if (bus3.ack_o !== 1'b1) begin miscompares++; $display("FAIL ws_ack2: got %b want 1", bus3.ack_o); end
    vectors++; if (bus3.dat_o !== 16'h6B6B) begin miscompares++; $display("FAIL ws_dat2: got %h want 6b6b", bus3.dat_o); end
    idle3();
    tick();
    vectors++; if (bus3.ack_o !== 1'b0) begin miscompares++; $display("FAIL ws_end_ack: got %b want 0", bus3.ack_o); end
  endtask

  task automatic test_abort();
    req3(1'b1, 16'h0010, 2'b11, 16'hBEEF);
    tick();
    bus3.stb_i = 1'b0;
    vectors++; if (bus3.stall_o !== 1'b1) begin miscompares++; $display("FAIL ab_stall_t1: got %b want 1", bus3.stall_o); end
    tick();
    idle3();
    tick();
    vectors++; if (bus3.stall_o !== 1'b0) begin miscompares++; $display("FAIL ab_stall_t3: got %b want 0", bus3.stall_o); end
    vectors++; if (bus3.ack_o !== 1'b0) begin miscompares++; $display("FAIL ab_ack_t3: got %b want 0", bus3.ack_o); end
    tick();
    vectors++; if (bus3.ack_o !== 1'b0) begin miscompares++; $display("FAIL ab_ack_t4: got %b want 0", bus3.ack_o); end
    req3(1'b0, 16'h0010, 2'b11, 16'h0000);
    tick();
    bus3.stb_i = 1'b0;
    repeat (3) tick();
    vectors++; if (bus3.ack_o !== 1'b1) begin miscompares++; $display("FAIL ab_rd_ack: got %b want 1", bus3.ack_o); end
    vectors++; if (bus3.dat_o !== 16'hBEEF) begin miscompares++; $display("FAIL ab_rd_dat: got %h want beef", bus3.dat_o); end
    idle3();
    tick();
  endtask

`ifdef WB_RAM_ERR_EN
  task automatic test_err();
    buse.cyc_i = 1'b1; buse.stb_i = 1'b1; buse.we_i = 1'b1;
    buse.adr_i = 16'h0000; buse.sel_i = 2'b11; buse.dat_i = 16'h5555;
    tick();
    vectors++; if (buse.ack_o !== 1'b1) begin miscompares++; $display("FAIL err_pre_ack: got %b want 1", buse.ack_o); end
    buse.adr_i = 16'h0400; buse.dat_i = 16'h1234;
    tick();
    vectors++; if (buse.err_o !== 1'b1) begin miscompares++; $display("FAIL err_oor_err: got %b want 1", buse.err_o); end
    vectors++; if (buse.ack_o !== 1'b0) begin miscompares++; $display("FAIL err_oor_ack: got %b want 0", buse.ack_o); end
    buse.we_i = 1'b0; buse.adr_i = 16'h0000;
    tick();
    vectors++; if (buse.ack_o !== 1'b1) begin miscompares++; $display("FAIL err_rd_ack: got %b want 1", buse.ack_o); end
    vectors++; if (buse.err_o !== 1'b0) begin miscompares++; $display("FAIL err_rd_err: got %b want 0", buse.err_o); end
    vectors++; if (buse.dat_o !== 16'h5555) begin miscompares++; $display("FAIL err_rd_dat: got %h want 5555", buse.dat_o); end
    buse.cyc_i = 1'b0; buse.stb_i = 1'b0;
    tick();
    vectors++; if (buse.err_o !== 1'b0) begin miscompares++; $display("FAIL err_idle: got %b want 0", buse.err_o); end
  endtask
`endif

  task automatic test_reset_mid();
    req3(1'b0, 16'h0005, 2'b11, 16'h0000);
    tick();
    bus3.stb_i = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    vectors++; if (bus3.stall_o !== 1'b0) begin miscompares++; $display("FAIL rm_stall: got %b want 0", bus3.stall_o); end
    vectors++; if (bus3.dat_o !== 16'h0000) begin miscompares++; $display("FAIL rm_dat: got %h want 0000", bus3.dat_o); end
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++; if (bus3.ack_o !== 1'b0) begin miscompares++; $display("FAIL rm_ack[%0d]: got %b want 0", k, bus3.ack_o); end
    end
    idle3();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle0();
    idle3();
    bus0.adr_i = '0; bus0.sel_i = '0; bus0.dat_i = '0;
    bus3.adr_i = '0; bus3.sel_i = '0; bus3.dat_i = '0;
`ifdef WB_RAM_ERR_EN
    buse.cyc_i = 1'b0; buse.stb_i = 1'b0; buse.we_i = 1'b0;
    buse.adr_i = '0;   buse.sel_i = '0;   buse.dat_i = '0;
`endif
    test_reset();
    test_byte_lanes();
    test_back_to_back();
    test_wait_states();
    test_abort();
`ifdef WB_RAM_ERR_EN
    test_err();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
